// File: rtl/enc_req_arbiter.sv
// enc_req_arbiter
//   Shares one stage-1 systematic encoder between NUM_REQ requesters.
//   Requests are granted round-robin, at most one per cycle. The granted info
//   word and work mode are registered onto the encoder inputs. A tag pipe
//   follows each job through the encoder's fixed latency so that the codeword
//   goes back to the requester that issued it.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   i_hold          : blocks new grants; jobs already in flight still drain
//   i_req_valid     : per-requester request valid
//   o_req_ready     : per-requester grant (one-hot or zero)
//   i_req_data      : packed info words, requester i at [i*MAX_INFO_WIDTH +: MAX_INFO_WIDTH]
//   i_req_mod       : packed work modes, requester i at [i*2 +: 2] (11 is illegal)
//   o_enc_data_in   : registered encoder data_in
//   o_enc_work_mod  : registered encoder work_mod (11 when idle)
//   i_enc_data_out  : encoder codeword output
//   o_resp_valid    : one-cycle response pulse
//   o_resp_id       : requester owning the response
//   o_resp_data     : codeword, forced to 0 on an illegal-mode job
//   o_resp_err      : job was issued with illegal mode 11
//   o_busy          : at least one job in flight
module enc_req_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int ENC_LATENCY        = 2,
  parameter int ID_W               = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_hold,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ*MAX_INFO_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ*2-1:0]            i_req_mod,
  output logic [MAX_INFO_WIDTH-1:0]       o_enc_data_in,
  output logic [1:0]                      o_enc_work_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0]   i_enc_data_out,
  output logic                            o_resp_valid,
  output logic [ID_W-1:0]                 o_resp_id,
  output logic [MAX_CODEWORD_WIDTH-1:0]   o_resp_data,
  output logic                            o_resp_err,
  output logic                            o_busy
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]           r_ptr;
  logic [MAX_INFO_WIDTH-1:0] r_encData;
  logic [1:0]                r_encMod;
  logic [ENC_LATENCY:0]      r_tagValid;
  logic [ENC_LATENCY:0]      r_tagErr;
  logic [ID_W-1:0]           r_tagId [ENC_LATENCY+1];

  logic                      w_found;
  logic                      w_doGrant;
  logic [ID_W-1:0]           w_grantIdx;
  logic [ID_W-1:0]           w_cand;
  logic [MAX_INFO_WIDTH-1:0] w_selData;
  logic [1:0]                w_selMod;

  // Wrapping increment; NUM_REQ need not be a power of two.
  function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    w_cand     = f_next(r_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[w_cand]) begin
        w_found    = 1'b1;
        w_grantIdx = w_cand;
      end
      w_cand = f_next(w_cand);
    end
    w_doGrant = w_found && !i_hold && !rst;
  end

  always_comb begin
    o_req_ready = '0;
    if (w_doGrant) begin
      o_req_ready[w_grantIdx] = 1'b1;
    end
  end

  // Slice mux with constant indices for the granted requester.
  always_comb begin
    w_selData = '0;
    w_selMod  = 2'b11;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grantIdx == ID_W'(i)) begin
        w_selData = i_req_data[i*MAX_INFO_WIDTH +: MAX_INFO_WIDTH];
        w_selMod  = i_req_mod[i*2 +: 2];
      end
    end
  end

  // Idle cycles drive mode 11 with zero data so the encoder emits zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= LAST_IDX;
      r_encData <= '0;
      r_encMod  <= 2'b11;
    end else if (w_doGrant) begin
      r_ptr     <= w_grantIdx;
      r_encData <= w_selData;
      r_encMod  <= w_selMod;
    end else begin
      r_encData <= '0;
      r_encMod  <= 2'b11;
    end
  end

  // Stage 0 is loaded at the grant edge; stage ENC_LATENCY lines up with
  // the encoder output for that job.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tagValid <= '0;
      r_tagErr   <= '0;
      for (int s = 0; s <= ENC_LATENCY; s++) begin
        r_tagId[s] <= '0;
      end
    end else begin
      r_tagValid <= {r_tagValid[ENC_LATENCY-1:0], w_doGrant};
      r_tagErr   <= {r_tagErr[ENC_LATENCY-1:0], w_doGrant && (w_selMod == 2'b11)};
      r_tagId[0] <= w_doGrant ? w_grantIdx : '0;
      for (int s = 1; s <= ENC_LATENCY; s++) begin
        r_tagId[s] <= r_tagId[s-1];
      end
    end
  end

  always_comb begin
    o_resp_valid = r_tagValid[ENC_LATENCY];
    o_resp_err   = r_tagValid[ENC_LATENCY] && r_tagErr[ENC_LATENCY];
    o_resp_id    = r_tagValid[ENC_LATENCY] ? r_tagId[ENC_LATENCY] : '0;
    o_resp_data  = (r_tagValid[ENC_LATENCY] && !r_tagErr[ENC_LATENCY]) ? i_enc_data_out : '0;
  end

  assign o_busy         = |r_tagValid;
  assign o_enc_data_in  = r_encData;
  assign o_enc_work_mod = r_encMod;

endmodule

// File: tb/tb_enc_req_arbiter.sv
// tb_enc_req_arbiter
//   Testbench for enc_req_arbiter. A behavioural encoder with the same fixed
//   latency feeds the codeword port. A negedge monitor keeps its own
//   round-robin model, pushes expected responses into a scoreboard queue on
//   every predicted grant, and pops them when they fall due. Scenario tasks
//   add targeted checks of their own.
module tb_enc_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int INFO_W  = 26;
  localparam int CW_W    = 32;
  localparam int LAT     = 2;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      hold = 1'b0;
  logic [NUM_REQ-1:0]        reqValid = '0;
  logic [NUM_REQ-1:0]        reqReady;
  logic [NUM_REQ*INFO_W-1:0] reqData = '0;
  logic [NUM_REQ*2-1:0]      reqMod = '0;
  logic [INFO_W-1:0]         encDataIn;
  logic [1:0]                encMod;
  logic [CW_W-1:0]           encDataOut;
  logic                      respValid;
  logic [ID_W-1:0]           respId;
  logic [CW_W-1:0]           respData;
  logic                      respErr;
  logic                      busy;

  int passCnt  = 0;
  int totalCnt = 0;
  int cyc      = 0;

  enc_req_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_INFO_WIDTH(INFO_W), .MAX_CODEWORD_WIDTH(CW_W),
    .ENC_LATENCY(LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .i_hold(hold),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_data(reqData), .i_req_mod(reqMod),
    .o_enc_data_in(encDataIn), .o_enc_work_mod(encMod),
    .i_enc_data_out(encDataOut),
    .o_resp_valid(respValid), .o_resp_id(respId), .o_resp_data(respData),
    .o_resp_err(respErr), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW_W-1:0] cwModel(input logic [INFO_W-1:0] d, input logic [1:0] m);
    return (m == 2'b11) ? 32'h0 : {4'h0, m, d};
  endfunction

  // Behavioural encoder: LAT register stages after the registered inputs.
  logic [CW_W-1:0] encPipe [LAT];
  always @(posedge clk) begin
    encPipe[0] <= cwModel(encDataIn, encMod);
    for (int i = 1; i < LAT; i++) encPipe[i] <= encPipe[i-1];
  end
  assign encDataOut = encPipe[LAT-1];

  typedef struct {
    int              due;
    int              id;
    logic            err;
    logic [CW_W-1:0] data;
  } respT;

  respT            sb[$];
  int              modelPtr   = NUM_REQ - 1;
  logic [INFO_W-1:0] expEncData = '0;
  logic [1:0]      expEncMod  = 2'b11;
  bit              monEn      = 1'b0;

  // Scoreboard monitor: predicts grants, encoder inputs, busy and responses.
  always @(negedge clk) begin
    if (monEn) begin
      int gIdx;
      logic [NUM_REQ-1:0] expReady;
      logic expBusy;
      gIdx = -1;
      if (!rst && !hold) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (modelPtr + k) % NUM_REQ;
          if (gIdx < 0 && reqValid[c]) gIdx = c;
        end
      end
      expReady = (gIdx >= 0) ? (NUM_REQ'(1) << gIdx) : '0;
      totalCnt++;
      if (reqReady !== expReady)
        $display("[TB] FAIL mon_ready cyc=%0d: got %b expected %b", cyc, reqReady, expReady);
      else passCnt++;
      totalCnt++;
      if ({encMod, encDataIn} !== {expEncMod, expEncData})
        $display("[TB] FAIL mon_enc_in cyc=%0d: got %b/%h expected %b/%h", cyc, encMod, encDataIn, expEncMod, expEncData);
      else passCnt++;
      expBusy = (sb.size() != 0);
      totalCnt++;
      if (busy !== expBusy)
        $display("[TB] FAIL mon_busy cyc=%0d: got %b expected %b", cyc, busy, expBusy);
      else passCnt++;
      if (sb.size() != 0 && sb[0].due == cyc) begin
        respT e;
        e = sb.pop_front();
        totalCnt++;
        if ({respValid, respId, respErr, respData} !== {1'b1, ID_W'(e.id), e.err, e.data})
          $display("[TB] FAIL mon_resp cyc=%0d: got v=%b id=%0d err=%b data=%h expected v=1 id=%0d err=%b data=%h",
                   cyc, respValid, respId, respErr, respData, e.id, e.err, e.data);
        else passCnt++;
      end else begin
        totalCnt++;
        if ({respValid, respId, respErr, respData} !== '0)
          $display("[TB] FAIL mon_idle_resp cyc=%0d: got v=%b id=%0d err=%b data=%h expected all zero",
                   cyc, respValid, respId, respErr, respData);
        else passCnt++;
      end
      if (rst) begin
        sb.delete();
        modelPtr   = NUM_REQ - 1;
        expEncData = '0;
        expEncMod  = 2'b11;
      end else if (gIdx >= 0) begin
        respT n;
        logic [INFO_W-1:0] d;
        logic [1:0] m;
        d = reqData[gIdx*INFO_W +: INFO_W];
        m = reqMod[gIdx*2 +: 2];
        n.due  = cyc + 1 + LAT;
        n.id   = gIdx;
        n.err  = (m == 2'b11);
        n.data = cwModel(d, m);
        sb.push_back(n);
        modelPtr   = gIdx;
        expEncData = d;
        expEncMod  = m;
      end else begin
        expEncData = '0;
        expEncMod  = 2'b11;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [INFO_W-1:0] d, input logic [1:0] m);
    reqData[i*INFO_W +: INFO_W] = d;
    reqMod[i*2 +: 2]            = m;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    monEn = 1'b1;
    reqValid = '1;
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", reqReady);
    else passCnt++;
    totalCnt++;
    if ({encMod, encDataIn} !== {2'b11, 26'h0})
      $display("[TB] FAIL reset_enc: got %b/%h expected 11/0", encMod, encDataIn);
    else passCnt++;
    totalCnt++;
    if ({respValid, busy} !== 2'b00) $display("[TB] FAIL reset_resp_busy: got %b expected 00", {respValid, busy});
    else passCnt++;
    tick();
    reqValid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_job();
    setReq(2, 26'h5A3, 2'b01);
    reqValid = 4'b0100;
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 4'b0100) $display("[TB] FAIL single_ready: got %b expected 0100", reqReady);
    else passCnt++;
    tick();
    reqValid = '0;
    @(negedge clk);
    totalCnt++;
    if ({encMod, encDataIn} !== {2'b01, 26'h5A3})
      $display("[TB] FAIL single_enc: got %b/%h expected 01/5a3", encMod, encDataIn);
    else passCnt++;
    tick();
    tick();
    @(negedge clk);
    totalCnt++;
    if ({respValid, respId, respErr, respData} !== {1'b1, 2'd2, 1'b0, 32'h0400_05A3})
      $display("[TB] FAIL single_resp: got v=%b id=%0d err=%b data=%h expected v=1 id=2 err=0 data=040005a3",
               respValid, respId, respErr, respData);
    else passCnt++;
    tick();
  endtask

  task automatic test_round_robin();
    pulseReset();
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 26'h100000 + INFO_W'(i * 17), 2'(i % 3));
    reqValid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      totalCnt++;
      if (reqReady !== (NUM_REQ'(1) << (k % NUM_REQ)))
        $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, reqReady, NUM_REQ'(1) << (k % NUM_REQ));
      else passCnt++;
      tick();
    end
    reqValid = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_illegal_mode();
    setReq(1, 26'h3FFFFFF, 2'b11);
    reqValid = 4'b0010;
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 4'b0010) $display("[TB] FAIL illegal_ready: got %b expected 0010", reqReady);
    else passCnt++;
    tick();
    reqValid = '0;
    @(negedge clk);
    totalCnt++;
    if ({encMod, encDataIn} !== {2'b11, 26'h3FFFFFF})
      $display("[TB] FAIL illegal_enc: got %b/%h expected 11/3ffffff", encMod, encDataIn);
    else passCnt++;
    tick();
    tick();
    @(negedge clk);
    totalCnt++;
    if ({respValid, respId, respErr, respData} !== {1'b1, 2'd1, 1'b1, 32'h0})
      $display("[TB] FAIL illegal_resp: got v=%b id=%0d err=%b data=%h expected v=1 id=1 err=1 data=0",
               respValid, respId, respErr, respData);
    else passCnt++;
    tick();
  endtask

  task automatic test_hold();
    int respSeen;
    bit drained;
    pulseReset();
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 26'h2A0000 + INFO_W'(i), 2'b10);
    reqValid = '1;
    repeat (3) tick();
    hold = 1'b1;
    respSeen = 0;
    drained  = 1'b0;
    for (int n = 0; n < 10 && !drained; n++) begin
      @(negedge clk);
      totalCnt++;
      if (reqReady !== 4'b0000) $display("[TB] FAIL hold_ready_%0d: got %b expected 0000", n, reqReady);
      else passCnt++;
      if (respValid === 1'b1) respSeen++;
      if (busy === 1'b0) drained = 1'b1;
      else tick();
    end
    totalCnt++;
    if (!drained || respSeen != 3)
      $display("[TB] FAIL hold_drain: got drained=%0d responses=%0d expected drained=1 responses=3", drained, respSeen);
    else passCnt++;
    tick();
    hold = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 4'b1000) $display("[TB] FAIL hold_resume: got %b expected 1000", reqReady);
    else passCnt++;
    tick();
    reqValid = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_reset_mid();
    setReq(0, 26'h0000AB, 2'b00);
    setReq(1, 26'h0000CD, 2'b01);
    reqValid = 4'b0011;
    tick();
    tick();
    reqValid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      totalCnt++;
      if ({respValid, busy, encMod} !== {1'b0, 1'b0, 2'b11})
        $display("[TB] FAIL rstmid_quiet_%0d: got v=%b busy=%b mod=%b expected v=0 busy=0 mod=11",
                 n, respValid, busy, encMod);
      else passCnt++;
      tick();
    end
    reqValid = '1;
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 4'b0001) $display("[TB] FAIL rstmid_first_grant: got %b expected 0001", reqReady);
    else passCnt++;
    tick();
    reqValid = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_sparse();
    setReq(3, 26'h155555, 2'b00);
    reqValid = 4'b0010;
    tick();
    for (int k = 0; k < 6; k++) begin
      reqValid = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      totalCnt++;
      if (reqReady !== reqValid) $display("[TB] FAIL sparse_%0d: got %b expected %b", k, reqReady, reqValid);
      else passCnt++;
      tick();
    end
    reqValid = 4'b1001;
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 4'b0001) $display("[TB] FAIL sparse_req0_first: got %b expected 0001", reqReady);
    else passCnt++;
    tick();
    reqValid = 4'b1000;
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 4'b1000) $display("[TB] FAIL sparse_req3_after: got %b expected 1000", reqReady);
    else passCnt++;
    tick();
    reqValid = '0;
    repeat (LAT + 3) tick();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_illegal_mode();
    test_hold();
    test_reset_mid();
    test_sparse();
    totalCnt++;
    if (sb.size() != 0) $display("[TB] FAIL sb_leftover: got %0d expected 0", sb.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/enc_req_arbiter.md
Name: enc_req_arbiter

Overview:
- Shares the single stage-1 systematic encoder (data_in/work_mod in, 32-bit zero-padded codeword out) between NUM_REQ independent requesters.
- Arbitrates round-robin, accepting at most one request per cycle, and drives the encoder inputs from a register.
- Tracks each in-flight job through the encoder's fixed pipeline latency with a tag shift register, then returns the codeword to the originating requester with its ID.
- Sits between the per-channel front ends and the encoder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_INFO_WIDTH, 26, info word width, matches the encoder.
- MAX_CODEWORD_WIDTH, 32, codeword width, matches the encoder.
- ENC_LATENCY, 2, cycles from encoder input change to corresponding data_out (≥1).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- hold  in  1  when high, no new grants; in-flight jobs drain normally.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_data  in  NUM_REQ*MAX_INFO_WIDTH  info words; requester i uses slice [i*MAX_INFO_WIDTH +: MAX_INFO_WIDTH].
- req_mod  in  NUM_REQ*2  work modes, slice [i*2 +: 2]; 00/01/10 valid, 11 illegal.
- enc_data_in  out  MAX_INFO_WIDTH  to encoder data_in (registered).
- enc_work_mod  out  2  to encoder work_mod (registered).
- enc_data_out  in  MAX_CODEWORD_WIDTH  from encoder data_out.
- resp_valid  out  1  one-cycle pulse, codeword available.
- resp_id  out  ID_W  requester that owns resp_data.
- resp_data  out  MAX_CODEWORD_WIDTH  codeword; 0 when resp_err.
- resp_err  out  1  job had illegal mode 11.
- busy  out  1  any job in flight.

Behaviour:
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid, hold and the RR pointer. The requester must hold valid/data/mod stable until ready. Deasserting valid before grant is allowed.
- Arbitration:
  - Search starts at ptr+1 mod NUM_REQ, ascending with wrap.
  - The first valid requester is granted. ptr updates to the granted index on a grant only.
  - Reset ptr = NUM_REQ-1, so req 0 has first priority.
  - hold=1 or no valid gives req_ready=0 and ptr unchanged.
- Issue: on a grant in cycle T, enc_data_in/enc_work_mod load the granted slices at the T edge, visible from T+1.
  - Cycles with no grant: enc_data_in=0 and enc_work_mod=2'b11, so the encoder emits zeros.
  - Illegal mode 11 is still accepted and forwarded as 11.
- Tag pipe: (valid, id, err) enters stage 0 at the grant edge and shifts one stage per cycle, depth ENC_LATENCY+1. Throughput is 1 job/cycle, with no output backpressure.
- Response (combinational from the last tag stage):
  - resp_valid asserts in cycle T+1+ENC_LATENCY.
  - resp_id = tag id.
  - resp_data = enc_data_out, or 0 if err.
  - resp_err = tag err.
  - When the tag is invalid: resp_id=0, resp_data=0, resp_err=0.
- busy = OR of all tag valid bits.
- Ordering: responses leave strictly in grant order.
- Reset (sync): clears the tag pipe, sets ptr=NUM_REQ-1, enc_data_in=0, enc_work_mod=2'b11. All outputs are therefore 0 except enc_work_mod=11. Jobs in flight are discarded with no response. req_ready=0 while rst=1.
- Simultaneous events:
  - Grant and a response in the same cycle are independent.
  - hold rising in the same cycle as valid blocks that grant.

Test Plan:
- Single job: req 2 valid, mode 01, data 11'h5A3, from idle → req_ready=4'b0100 in T. enc_work_mod=01 and enc_data_in=11'h5A3 at T+1. resp_valid at T+3 with resp_id=2 and resp_data equal to enc_data_out that cycle (reference-model codeword, bits[31:16]=0).
- Round robin: all 4 requesters valid continuously after reset → grants 0,1,2,3,0,… one per cycle. Responses arrive back-to-back with ids in the same order.
- Illegal mode: req 1 mode 11 → accepted. resp_valid with resp_id=1, resp_err=1, resp_data=0, 3 cycles after grant.
- Hold: hold=1 with 3 jobs in flight and all requesters valid → req_ready=0. The 3 responses still emerge and busy falls after the last. Releasing hold resumes arbitration from ptr+1.
- Reset mid-flight: assert rst with 2 jobs in pipe → no resp_valid afterwards, busy=0, enc_work_mod=11. Next grant goes to the lowest valid index starting at 0.
- Sparse valid: only req 3 toggling valid every other cycle → granted every time it is valid. ptr stays at 3, and a later req 0 request gets granted before req 3.
